counter_timer_gen: RTL and testbench

Parametrised next-generation counter/timer core. Width is configurable. Adds a clock prescaler, a compare-match register, an optional external capture input, and a sticky W1C status register driving a level interrupt. It sits behind a Wishbone register wrapper (decode/ack done outside), one instance per timer channel.

---
 rtl/counter_timer_gen.sv | 163 ++++++++++++++++
 tb/tb_counter_timer_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_gen.sv
// counter_timer_gen: prescaled up/down counter/timer with compare match, sticky W1C status and level irq.
// Define CTR_CAPTURE_EN to build the synchronised external capture input and capture register.
module counter_timer_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic [3:0]         reg_cfg_we,
  input  logic [31:0]        reg_cfg_di,
  output logic [31:0]        reg_cfg_do,
  input  logic [WIDTH/8-1:0] reg_val_we,
  input  logic [WIDTH-1:0]   reg_val_di,
  output logic [WIDTH-1:0]   reg_val_do,
  input  logic [WIDTH/8-1:0] reg_dat_we,
  input  logic [WIDTH-1:0]   reg_dat_di,
  output logic [WIDTH-1:0]   reg_dat_do,
  input  logic [WIDTH/8-1:0] reg_cmp_we,
  input  logic [WIDTH-1:0]   reg_cmp_di,
  output logic [WIDTH-1:0]   reg_cmp_do,
  input  logic               reg_sts_we,
  input  logic [2:0]         reg_sts_di,
  output logic [2:0]         reg_sts_do,
  output logic [WIDTH-1:0]   reg_cap_do,
  input  logic               capture_in,
  output logic               match_out,
  output logic               irq_out
);
  localparam int unsigned NB       = WIDTH / 8;
  localparam int unsigned CFG_BITS = 8 + PRESCALE_W;
  localparam logic [31:0] CFG_MASK = 32'((64'd1 << CFG_BITS) - 64'd1);

  function automatic logic [WIDTH-1:0] lane_mask(input logic [NB-1:0] we);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{we[i]}};
    return m;
  endfunction

  logic [31:0]           cfg_wm;
  logic [31:0]           cfg_next;
  logic [WIDTH-1:0]      val_wm, dat_wm, cmp_wm;
  logic [WIDTH-1:0]      value_next;
  logic [WIDTH-1:0]      terminal;
  logic [PRESCALE_W-1:0] pre_cnt, pre_next, prescale;
  logic [2:0]            irq_ena, sts_clr, sts_next;
  logic                  enable, oneshot, up;
  logic                  lastenable, done, done_next;
  logic                  arm, dat_wr, tick, at_term;
  logic                  timeout_ev, match_ev, cap_ev;

  assign enable   = reg_cfg_do[0];
  assign oneshot  = reg_cfg_do[1];
  assign up       = reg_cfg_do[2];
  assign irq_ena  = reg_cfg_do[5:3];
  assign prescale = reg_cfg_do[8 +: PRESCALE_W];

  always_comb begin
    cfg_wm = '0;
    for (int i = 0; i < 4; i++) cfg_wm[i*8 +: 8] = {8{reg_cfg_we[i]}};
  end

  assign cfg_next = ((reg_cfg_do & ~cfg_wm) | (reg_cfg_di & cfg_wm)) & CFG_MASK;
  assign val_wm   = lane_mask(reg_val_we);
  assign dat_wm   = lane_mask(reg_dat_we);
  assign cmp_wm   = lane_mask(reg_cmp_we);

  // A current-value write pre-empts any tick in the same cycle.
  assign arm        = enable & ~lastenable;
  assign dat_wr     = |reg_dat_we;
  assign tick       = enable & lastenable & ~done & ~dat_wr & (pre_cnt == prescale);
  assign terminal   = up ? reg_val_do : '0;
  assign at_term    = (reg_dat_do == terminal);
  assign timeout_ev = tick & at_term;
  assign match_ev   = tick & (reg_dat_do == reg_cmp_do);

  always_comb begin
    pre_next = pre_cnt + PRESCALE_W'(1);
    if (!enable || arm || dat_wr || (pre_cnt == prescale)) pre_next = '0;
  end

  always_comb begin
    value_next = reg_dat_do;
    done_next  = done;
    if (arm) done_next = 1'b0;
    else if (timeout_ev && oneshot) done_next = 1'b1;
    if (dat_wr) begin
      value_next = (reg_dat_do & ~dat_wm) | (reg_dat_di & dat_wm);
    end else if (arm) begin
      value_next = up ? '0 : reg_val_do;
    end else if (tick) begin
      if (at_term) value_next = oneshot ? reg_dat_do : (up ? '0 : reg_val_do);
      else         value_next = up ? reg_dat_do + WIDTH'(1) : reg_dat_do - WIDTH'(1);
    end
  end

  // Event set wins over a simultaneous W1C of the same bit.
  assign sts_clr  = reg_sts_we ? reg_sts_di : 3'b000;
  assign sts_next = (reg_sts_do & ~sts_clr) | {cap_ev, match_ev, timeout_ev};

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      reg_cfg_do <= '0;
      reg_val_do <= '0;
      reg_dat_do <= '0;
      reg_cmp_do <= '0;
      reg_sts_do <= '0;
      pre_cnt    <= '0;
      lastenable <= 1'b0;
      done       <= 1'b0;
      match_out  <= 1'b0;
      irq_out    <= 1'b0;
    end else begin
      reg_cfg_do <= cfg_next;
      reg_val_do <= (reg_val_do & ~val_wm) | (reg_val_di & val_wm);
      reg_dat_do <= value_next;
      reg_cmp_do <= (reg_cmp_do & ~cmp_wm) | (reg_cmp_di & cmp_wm);
      reg_sts_do <= sts_next;
      pre_cnt    <= pre_next;
      lastenable <= enable;
      done       <= done_next;
      match_out  <= match_ev;
      irq_out    <= |(reg_sts_do & irq_ena);
    end
  end

`ifdef CTR_CAPTURE_EN
  // [1:0] synchroniser, [2] previous synchronised level for edge detection.
  logic [2:0] cap_sync;
  logic [1:0] edge_sel;
  logic       cap_rise, cap_fall;

  assign edge_sel = reg_cfg_do[7:6];
  assign cap_rise = cap_sync[1] & ~cap_sync[2];
  assign cap_fall = ~cap_sync[1] & cap_sync[2];

  always_comb begin
    cap_ev = 1'b0;
    case (edge_sel)
      2'b00:   cap_ev = cap_rise;
      2'b01:   cap_ev = cap_fall;
      2'b10:   cap_ev = cap_rise | cap_fall;
      default: cap_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cap_sync   <= '0;
      reg_cap_do <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_in};
      if (cap_ev) reg_cap_do <= reg_dat_do;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign cap_ev         = 1'b0;
  assign reg_cap_do     = '0;
`endif

endmodule

// File: tb/tb_counter_timer_gen.sv
// Self-checking bench for counter_timer_gen: directed scenarios plus randomized runs against a
// closed-form tick-count model. Capture checks follow the CTR_CAPTURE_EN build option.
`timescale 1ns/1ps
module tb_counter_timer_gen;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NB    = WIDTH / 8;

  logic             clkin = 1'b0;
  logic             resetn = 1'b0;
  logic [3:0]       reg_cfg_we = '0;
  logic [31:0]      reg_cfg_di = '0;
  logic [31:0]      reg_cfg_do;
  logic [NB-1:0]    reg_val_we = '0;
  logic [WIDTH-1:0] reg_val_di = '0;
  logic [WIDTH-1:0] reg_val_do;
  logic [NB-1:0]    reg_dat_we = '0;
  logic [WIDTH-1:0] reg_dat_di = '0;
  logic [WIDTH-1:0] reg_dat_do;
  logic [NB-1:0]    reg_cmp_we = '0;
  logic [WIDTH-1:0] reg_cmp_di = '0;
  logic [WIDTH-1:0] reg_cmp_do;
  logic             reg_sts_we = 1'b0;
  logic [2:0]       reg_sts_di = '0;
  logic [2:0]       reg_sts_do;
  logic [WIDTH-1:0] reg_cap_do;
  logic             capture_in = 1'b0;
  logic             match_out;
  logic             irq_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference-model configuration for the randomized runs.
  int   m_rel, m_cmp, m_p;
  bit   m_up, m_one;
  logic [2:0] m_ena;

  counter_timer_gen #(.WIDTH(WIDTH), .PRESCALE_W(8)) dut (
    .clkin(clkin), .resetn(resetn),
    .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
    .reg_val_we(reg_val_we), .reg_val_di(reg_val_di), .reg_val_do(reg_val_do),
    .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
    .reg_cmp_we(reg_cmp_we), .reg_cmp_di(reg_cmp_di), .reg_cmp_do(reg_cmp_do),
    .reg_sts_we(reg_sts_we), .reg_sts_di(reg_sts_di), .reg_sts_do(reg_sts_do),
    .reg_cap_do(reg_cap_do), .capture_in(capture_in),
    .match_out(match_out), .irq_out(irq_out)
  );

  always #5 clkin = ~clkin;

  // Register write helpers: drive on a falling edge, return at the next falling edge.
  task automatic wr_cfg(input logic [3:0] we, input logic [31:0] d);
    reg_cfg_we = we; reg_cfg_di = d; @(negedge clkin); reg_cfg_we = '0;
  endtask
  task automatic wr_val(input logic [31:0] d);
    reg_val_we = '1; reg_val_di = d; @(negedge clkin); reg_val_we = '0;
  endtask
  task automatic wr_cmp(input logic [31:0] d);
    reg_cmp_we = '1; reg_cmp_di = d; @(negedge clkin); reg_cmp_we = '0;
  endtask
  task automatic wr_dat(input logic [3:0] we, input logic [31:0] d);
    reg_dat_we = we; reg_dat_di = d; @(negedge clkin); reg_dat_we = '0;
  endtask
  task automatic w1c(input logic [2:0] m);
    reg_sts_we = 1'b1; reg_sts_di = m; @(negedge clkin); reg_sts_we = 1'b0;
  endtask
  task automatic setup(input logic [31:0] cfg_off, input logic [31:0] rel, input logic [31:0] cmpv);
    wr_cfg(4'hF, cfg_off); wr_val(rel); wr_cmp(cmpv); w1c(3'b111);
  endtask
  // Returns at the falling edge just after the arm cycle (sample index n = 0).
  task automatic arm(input logic [31:0] cfg_on);
    wr_cfg(4'hF, cfg_on); @(negedge clkin);
  endtask

  // Value after k ticks from arm, derived from the counting rules.
  function automatic int mval(input int k);
    if (m_up) return m_one ? ((k < m_rel) ? k : m_rel) : (k % (m_rel + 1));
    return m_one ? ((k < m_rel) ? (m_rel - k) : 0) : (m_rel - (k % (m_rel + 1)));
  endfunction
  // Ticks taken by n cycles after arm; oneshot stops after the terminal tick.
  function automatic int mticks(input int n);
    int t;
    t = n / (m_p + 1);
    if (m_one && t > m_rel + 1) t = m_rel + 1;
    return t;
  endfunction
  function automatic logic [2:0] mstatus(input int n);
    logic [2:0] s;
    int term;
    s = 3'b000;
    term = m_up ? m_rel : 0;
    for (int j = 1; j <= mticks(n); j++) begin
      if (mval(j - 1) == term)  s[0] = 1'b1;
      if (mval(j - 1) == m_cmp) s[1] = 1'b1;
    end
    return s;
  endfunction

  task automatic test_reset();
    logic [31:0] got;
    repeat (2) @(negedge clkin);
    vectors++;
    if ({reg_cfg_do, reg_val_do, reg_dat_do, reg_cmp_do, reg_cap_do, reg_sts_do, match_out, irq_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs cfg=%h dat=%h sts=%b irq=%b want all zero", reg_cfg_do, reg_dat_do, reg_sts_do, irq_out);
    end
    resetn = 1'b1;
    wr_cfg(4'hF, 32'hFFFF_FFFE);
    got = reg_cfg_do;
    vectors++;
    if (got !== 32'h0000_FFFE) begin
      miscompares++; $display("FAIL cfg_unimpl_bits got=%h want=0000fffe", got);
    end
    wr_cfg(4'b0010, 32'h0000_0000);
    vectors++;
    if (reg_cfg_do !== 32'h0000_00FE) begin
      miscompares++; $display("FAIL cfg_byte_lane got=%h want=000000fe", reg_cfg_do);
    end
    wr_cfg(4'hF, 32'h0);
  endtask

  task automatic test_down_oneshot();
    setup(32'h0A, 32'd3, 32'hFFFF_FFFF);
    arm(32'h0B);
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== 32'(n < 3 ? 3 - n : 0)) begin
        miscompares++; $display("FAIL oneshot_value n=%0d got=%0d want=%0d", n, reg_dat_do, (n < 3 ? 3 - n : 0));
      end
    end
    vectors++;
    if (reg_sts_do !== 3'b001 || irq_out !== 1'b1) begin
      miscompares++; $display("FAIL oneshot_timeout sts=%b irq=%b want sts=001 irq=1", reg_sts_do, irq_out);
    end
    w1c(3'b001);
    vectors++;
    if (reg_sts_do !== 3'b000) begin
      miscompares++; $display("FAIL oneshot_w1c sts=%b want 000", reg_sts_do);
    end
    @(negedge clkin);
    vectors++;
    if (irq_out !== 1'b0 || reg_dat_do !== 32'd0) begin
      miscompares++; $display("FAIL oneshot_irq_clear irq=%b dat=%0d want irq=0 dat=0", irq_out, reg_dat_do);
    end
  endtask

  task automatic test_up_prescale();
    int exp_v [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    setup(32'h0204, 32'd2, 32'hFFFF_FFFF);
    arm(32'h0205);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== 32'(exp_v[n]) || reg_sts_do[0] !== (n == 9)) begin
        miscompares++;
        $display("FAIL prescale_seq n=%0d got=%0d/%b want=%0d/%b", n, reg_dat_do, reg_sts_do[0], exp_v[n], (n == 9));
      end
    end
  endtask

  task automatic test_compare();
    setup(32'h14, 32'd9, 32'd5);
    arm(32'h15);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clkin);
      vectors++;
      if (match_out !== (n == 6) || reg_dat_do !== 32'(n) || reg_sts_do !== ((n >= 6) ? 3'b010 : 3'b000)
          || irq_out !== (n >= 7)) begin
        miscompares++;
        $display("FAIL compare n=%0d match=%b dat=%0d sts=%b irq=%b want match=%b dat=%0d irq=%b",
                 n, match_out, reg_dat_do, reg_sts_do, irq_out, (n == 6), n, (n >= 7));
      end
    end
  endtask

  task automatic test_capture();
    setup(32'h24, 32'd100, 32'hFFFF_FFFF);
    arm(32'h25);
    for (int n = 0; n <= 14; n++) begin
      if (n > 0) @(negedge clkin);
      if (n == 10) capture_in = 1'b1;
`ifdef CTR_CAPTURE_EN
      if (n == 12 || n == 13) begin
        vectors++;
        if (reg_cap_do !== ((n == 13) ? 32'd12 : 32'd0) || reg_sts_do !== ((n == 13) ? 3'b100 : 3'b000)) begin
          miscompares++; $display("FAIL capture_rise n=%0d cap=%0d sts=%b", n, reg_cap_do, reg_sts_do);
        end
      end
      if (n == 14) begin
        vectors++;
        if (irq_out !== 1'b1) begin
          miscompares++; $display("FAIL capture_irq got=%b want=1", irq_out);
        end
      end
`else
      if (n == 14) begin
        vectors++;
        if (reg_cap_do !== '0 || reg_sts_do !== 3'b000 || irq_out !== 1'b0) begin
          miscompares++; $display("FAIL capture_absent cap=%0d sts=%b irq=%b want 0", reg_cap_do, reg_sts_do, irq_out);
        end
      end
`endif
    end
    capture_in = 1'b0;
    w1c(3'b100);
    repeat (5) @(negedge clkin);
    vectors++;
    if (reg_sts_do[2] !== 1'b0 || reg_cap_do !== ((`ifdef CTR_CAPTURE_EN 1 `else 0 `endif) ? 32'd12 : 32'd0)) begin
      miscompares++; $display("FAIL capture_fall_ignored sts=%b cap=%0d", reg_sts_do, reg_cap_do);
    end
  endtask

  task automatic test_w1c_collision();
    int exp_v [6] = '{2, 1, 0, 2, 1, 0};
    setup(32'h08, 32'd2, 32'hFFFF_FFFF);
    arm(32'h09);
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== 32'(exp_v[n]) || reg_sts_do[0] !== (n >= 3) || irq_out !== (n >= 4)) begin
        miscompares++;
        $display("FAIL w1c_pre n=%0d dat=%0d sts=%b irq=%b", n, reg_dat_do, reg_sts_do, irq_out);
      end
    end
    w1c(3'b001);
    vectors++;
    if (reg_sts_do !== 3'b001 || irq_out !== 1'b1 || reg_dat_do !== 32'd2) begin
      miscompares++; $display("FAIL w1c_collision sts=%b irq=%b dat=%0d want sts=001 irq=1 dat=2", reg_sts_do, irq_out, reg_dat_do);
    end
    @(negedge clkin);
    w1c(3'b001);
    vectors++;
    if (reg_sts_do !== 3'b000 || reg_dat_do !== 32'd0) begin
      miscompares++; $display("FAIL w1c_plain sts=%b dat=%0d want sts=000 dat=0", reg_sts_do, reg_dat_do);
    end
    @(negedge clkin);
    vectors++;
    if (irq_out !== 1'b0 || reg_sts_do !== 3'b001) begin
      miscompares++; $display("FAIL w1c_rearm irq=%b sts=%b want irq=0 sts=001", irq_out, reg_sts_do);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int n_cyc;
      logic [31:0] cfg;
      logic [2:0] exp_s;
      logic exp_m, exp_i;
      m_rel = int'($urandom_range(0, 12));
      m_cmp = int'($urandom_range(0, 32'(m_rel + 1)));
      m_p   = int'($urandom_range(0, 3));
      m_up  = 1'($urandom_range(0, 1));
      m_one = 1'($urandom_range(0, 1));
      m_ena = 3'($urandom_range(0, 7));
      cfg = {16'h0, 8'(m_p), 2'b00, m_ena, m_up, m_one, 1'b0};
      setup(cfg, 32'(m_rel), 32'(m_cmp));
      arm(cfg | 32'h1);
      n_cyc = (m_rel + 3) * (m_p + 1) * 2;
      for (int n = 0; n <= n_cyc; n++) begin
        if (n > 0) @(negedge clkin);
        exp_s = mstatus(n);
        exp_m = (n > 0) && (n % (m_p + 1) == 0) && (n / (m_p + 1) <= mticks(n))
                && (mval(n / (m_p + 1) - 1) == m_cmp);
        exp_i = (n > 0) && (|(mstatus(n - 1) & m_ena));
        vectors++;
        if (reg_dat_do !== 32'(mval(mticks(n)))) begin
          miscompares++; $display("FAIL rnd_value it=%0d n=%0d got=%0d want=%0d", it, n, reg_dat_do, mval(mticks(n)));
        end
        vectors++;
        if (reg_sts_do !== exp_s) begin
          miscompares++; $display("FAIL rnd_status it=%0d n=%0d got=%b want=%b", it, n, reg_sts_do, exp_s);
        end
        vectors++;
        if (match_out !== exp_m) begin
          miscompares++; $display("FAIL rnd_match it=%0d n=%0d got=%b want=%b", it, n, match_out, exp_m);
        end
        vectors++;
        if (irq_out !== exp_i) begin
          miscompares++; $display("FAIL rnd_irq it=%0d n=%0d got=%b want=%b", it, n, irq_out, exp_i);
        end
      end
    end
  endtask

  task automatic test_dat_write();
    setup(32'h0304, 32'h1000, 32'h12345);
    arm(32'h0305);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== 32'(n / 4)) begin
        miscompares++; $display("FAIL datwr_pre n=%0d got=%0d want=%0d", n, reg_dat_do, n / 4);
      end
    end
    wr_dat(4'b0001, 32'hAAAA_AA40);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== ((k < 4) ? 32'h40 : 32'h41)) begin
        miscompares++; $display("FAIL datwr_lane k=%0d got=%h want=%h", k, reg_dat_do, ((k < 4) ? 32'h40 : 32'h41));
      end
    end
    wr_dat(4'hF, 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clkin);
      vectors++;
      if (reg_dat_do !== ((k < 4) ? 32'hFFFF_FFFF : 32'h0)) begin
        miscompares++; $display("FAIL datwr_wrap k=%0d got=%h", k, reg_dat_do);
      end
    end
    @(negedge clkin);
    resetn = 1'b0;
    #1;
    vectors++;
    if ({reg_cfg_do, reg_val_do, reg_dat_do, reg_cmp_do, reg_cap_do, reg_sts_do, match_out, irq_out} !== '0) begin
      miscompares++; $display("FAIL midcount_reset cfg=%h dat=%h sts=%b irq=%b want all zero", reg_cfg_do, reg_dat_do, reg_sts_do, irq_out);
    end
    @(negedge clkin);
    resetn = 1'b1;
    repeat (3) @(negedge clkin);
    vectors++;
    if (reg_dat_do !== 32'd0 || reg_cfg_do !== 32'd0) begin
      miscompares++; $display("FAIL post_reset_idle dat=%h cfg=%h want 0", reg_dat_do, reg_cfg_do);
    end
  endtask

  initial begin
    test_reset();
    test_down_oneshot();
    test_up_prescale();
    test_compare();
    test_capture();
    test_w1c_collision();
    test_random();
    test_dat_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
